// File: rtl/rst_seq.sv
// ---------------------------------------------------------------------------
// rst_seq: sequenced multi-domain reset release with PLL-lock qualification
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rst_seq #(
  parameter int N_DOM   = 3,
  parameter int DLY_CYC = 16
) (
  input  logic             i_clk,
  input  logic             i_arst,
  input  logic             i_pll_lock,
  input  logic             i_sw_rst,
  output logic [N_DOM-1:0] o_srst,
  output logic             o_ready,
  output logic [1:0]       o_state
);

  localparam int CNT_W = (DLY_CYC > 1) ? $clog2(DLY_CYC) : 1;
  localparam int IDX_W = (N_DOM > 1) ? $clog2(N_DOM) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DLY_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DOM - 1);

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_REL       = 2'd1,
    ST_RUN       = 2'd2,
    ST_ASSERT    = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_DOM-1:0]   srst_q, srst_d;
  logic               ready_q, ready_d;
  logic               lock_meta_q, lock_s_q;
  logic               go_assert;

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      lock_meta_q <= 1'b0;
      lock_s_q    <= 1'b0;
      state_q     <= ST_WAIT_LOCK;
      cnt_q       <= '0;
      idx_q       <= '0;
      srst_q      <= '1;
      ready_q     <= 1'b0;
    end else begin
      lock_meta_q <= i_pll_lock;
      lock_s_q    <= lock_meta_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      srst_q      <= srst_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    srst_d    = srst_q;
    ready_d   = ready_q;
    go_assert = 1'b0;

    case (state_q)
      ST_WAIT_LOCK: begin
        // Lock loss here only restarts qualification; it is not a fault.
        if (i_sw_rst) begin
          go_assert = 1'b1;
        end else if (!lock_s_q) begin
          cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_REL;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REL: begin
        if (i_sw_rst || !lock_s_q) begin
          go_assert = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          for (int i = 0; i < N_DOM; i++) begin
            if (idx_q == IDX_W'(i)) srst_d[i] = 1'b0;
          end
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
            ready_d = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (i_sw_rst || !lock_s_q) go_assert = 1'b1;
      end
      ST_ASSERT: begin
        // Hold interval runs to completion regardless of lock or soft reset.
        srst_d  = '1;
        ready_d = 1'b0;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: go_assert = 1'b1;
    endcase

    if (go_assert) begin
      state_d = ST_ASSERT;
      srst_d  = '1;
      ready_d = 1'b0;
      cnt_d   = '0;
      idx_d   = '0;
    end
  end

  assign o_srst  = srst_q;
  assign o_ready = ready_q;
  assign o_state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_rst_seq: scoreboard bench for rst_seq with directed reset scenarios
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_rst_seq;

  localparam int N_DOM   = 3;
  localparam int DLY_CYC = 4;

  logic             clk;
  logic             arst;
  logic             pll_lock;
  logic             sw_rst;
  logic [N_DOM-1:0] srst;
  logic             ready;
  logic [1:0]       state;

  int n_tests = 0;
  int n_fail  = 0;
  int edge_n;

  typedef struct {
    int         cyc;
    logic [2:0] srst;
    logic       ready;
    logic [1:0] st;
    string      tag;
  } exp_t;

  exp_t exp_q[$];

  rst_seq #(.N_DOM(N_DOM), .DLY_CYC(DLY_CYC)) dut (
    .i_clk      (clk),
    .i_arst     (arst),
    .i_pll_lock (pll_lock),
    .i_sw_rst   (sw_rst),
    .o_srst     (srst),
    .o_ready    (ready),
    .o_state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge 1 is the first posedge after arst falls.
  always @(posedge clk or posedge arst) begin
    if (arst) edge_n <= 0;
    else      edge_n <= edge_n + 1;
  end

  task automatic push(input int cyc, input logic [2:0] s, input logic r,
                      input logic [1:0] st, input string tag);
    exp_t e;
    e.cyc = cyc; e.srst = s; e.ready = r; e.st = st; e.tag = tag;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string tag, input int cyc, input logic [2:0] s,
                     input logic r, input logic [1:0] st);
    n_tests++;
    if (srst !== s || ready !== r || state !== st) begin
      n_fail++;
      $display("FAIL %s edge %0d: got srst=%b ready=%b state=%0d, expected srst=%b ready=%b state=%0d",
               tag, cyc, srst, ready, state, s, r, st);
    end
  endtask

  // Monitor: compares the DUT outputs against the scoreboard after each edge.
  always @(negedge clk) begin
    if (!arst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_n) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s edge %0d: check missed, now at edge %0d", exp_q[0].tag, exp_q[0].cyc, edge_n);
        void'(exp_q.pop_front());
      end
      while (exp_q.size() > 0 && exp_q[0].cyc == edge_n) begin
        chk(exp_q[0].tag, edge_n, exp_q[0].srst, exp_q[0].ready, exp_q[0].st);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic wait_edge(input int k);
    do @(negedge clk); while (edge_n < k);
  endtask

  task automatic do_reset(input string tag);
    arst = 1'b1;
    #1;
    chk(tag, 0, 3'b111, 1'b0, 2'd0);
    repeat (2) @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation timed out, queue size %0d", exp_q.size());
    $fatal(1, "timeout");
  end

  initial begin
    arst = 1'b1; pll_lock = 1'b1; sw_rst = 1'b0;

    // Cold start, soft-reset pulse, held soft reset, lock loss in REL.
    do_reset("cold_rst");
    for (int c = 1; c <= 5; c++) push(c, 3'b111, 1'b0, 2'd0, "cold_wait");
    push(6,  3'b111, 1'b0, 2'd1, "cold_rel");
    push(9,  3'b111, 1'b0, 2'd1, "cold_pre0");
    push(10, 3'b110, 1'b0, 2'd1, "cold_d0");
    push(13, 3'b110, 1'b0, 2'd1, "cold_pre1");
    push(14, 3'b100, 1'b0, 2'd1, "cold_d1");
    push(17, 3'b100, 1'b0, 2'd1, "cold_pre2");
    push(18, 3'b000, 1'b1, 2'd2, "cold_run");
    push(20, 3'b000, 1'b1, 2'd2, "cold_run_hold");

    push(21, 3'b111, 1'b0, 2'd3, "sw_assert");
    push(24, 3'b111, 1'b0, 2'd3, "sw_hold_end");
    push(25, 3'b111, 1'b0, 2'd0, "sw_wait");
    push(28, 3'b111, 1'b0, 2'd0, "sw_qual");
    push(29, 3'b111, 1'b0, 2'd1, "sw_rel");
    push(32, 3'b111, 1'b0, 2'd1, "sw_pre0");
    push(33, 3'b110, 1'b0, 2'd1, "sw_d0");
    push(37, 3'b100, 1'b0, 2'd1, "sw_d1");
    push(40, 3'b100, 1'b0, 2'd1, "sw_pre2");
    push(41, 3'b000, 1'b1, 2'd2, "sw_run");
    push(42, 3'b000, 1'b1, 2'd2, "sw_run_hold");

    for (int c = 43; c <= 46; c++) push(c, 3'b111, 1'b0, 2'd3, "hold_a1");
    push(47, 3'b111, 1'b0, 2'd0, "hold_wait1");
    for (int c = 48; c <= 51; c++) push(c, 3'b111, 1'b0, 2'd3, "hold_a2");
    for (int c = 52; c <= 55; c++) push(c, 3'b111, 1'b0, 2'd0, "hold_wait2");
    push(56, 3'b111, 1'b0, 2'd1, "hold_rel");

    push(59, 3'b111, 1'b0, 2'd1, "ll_pre0");
    push(60, 3'b110, 1'b0, 2'd1, "ll_d0");
    push(63, 3'b110, 1'b0, 2'd1, "ll_pre1");
    push(64, 3'b111, 1'b0, 2'd3, "ll_assert");
    push(67, 3'b111, 1'b0, 2'd3, "ll_hold_end");
    for (int c = 68; c <= 77; c++) push(c, 3'b111, 1'b0, 2'd0, "ll_wait");
    push(78, 3'b111, 1'b0, 2'd1, "ll_rel");

    wait_edge(20); sw_rst = 1'b1;
    wait_edge(21); sw_rst = 1'b0;
    wait_edge(42); sw_rst = 1'b1;
    wait_edge(52); sw_rst = 1'b0;
    wait_edge(61); pll_lock = 1'b0;
    wait_edge(72); pll_lock = 1'b1;
    wait_edge(80);

    // Lock glitch during qualification.
    do_reset("glitch_rst");
    for (int c = 1; c <= 9; c++) push(c, 3'b111, 1'b0, 2'd0, "glitch_wait");
    push(10, 3'b111, 1'b0, 2'd1, "glitch_rel");
    push(13, 3'b111, 1'b0, 2'd1, "glitch_pre0");
    push(14, 3'b110, 1'b0, 2'd1, "glitch_d0");
    push(17, 3'b110, 1'b0, 2'd1, "glitch_pre1");
    push(18, 3'b100, 1'b0, 2'd1, "glitch_d1");
    wait_edge(3); pll_lock = 1'b0;
    wait_edge(4); pll_lock = 1'b1;
    wait_edge(19);

    // Asynchronous reset mid-sequence while o_srst=100.
    #2 arst = 1'b1;
    #1 chk("arst_mid", edge_n, 3'b111, 1'b0, 2'd0);
    @(negedge clk);
    arst = 1'b0;
    for (int c = 1; c <= 5; c++) push(c, 3'b111, 1'b0, 2'd0, "re_wait");
    push(6,  3'b111, 1'b0, 2'd1, "re_rel");
    push(10, 3'b110, 1'b0, 2'd1, "re_d0");
    push(14, 3'b100, 1'b0, 2'd1, "re_d1");
    push(18, 3'b000, 1'b1, 2'd2, "re_run");
    wait_edge(20);

    if (exp_q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d checks left unserved, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter N_DOM, default 3: number of sequenced reset domains; legal range 1..8.
REQ-002 Parameter DLY_CYC, default 16: qualification, spacing and hold interval in i_clk cycles; legal range 2..65535.
REQ-003 i_clk  in  1  single system clock; all logic on posedge.
REQ-004 i_arst  in  1  asynchronous, active-high reset for the whole block.
REQ-005 i_pll_lock  in  1  PLL lock, asynchronous to i_clk; internally synchronized by a 2-flop chain (lock_s).
REQ-006 i_sw_rst  in  1  synchronous soft-reset request, level or pulse; sampled each cycle.
REQ-007 o_srst  out  N_DOM  active-high per-domain synchronous reset; bit 0 releases first.
REQ-008 o_ready  out  1  high only when all domains are released (state RUN).
REQ-009 o_state  out  2  current FSM state: WAIT_LOCK=0, REL=1, RUN=2, ASSERT=3.

Function
REQ-010 All outputs SHALL be registered; there SHALL be no combinational path from any input to any output.
REQ-011 The FSM SHALL have exactly four states: WAIT_LOCK, REL, RUN, ASSERT.
REQ-012 The block SHALL keep an internal counter cnt (width ceil(log2(DLY_CYC))) and a domain index idx (width ceil(log2(N_DOM)), minimum 1 bit).
REQ-013 WAIT_LOCK, lock_s low: cnt SHALL be cleared to 0.
REQ-014 WAIT_LOCK, lock_s high and cnt<DLY_CYC-1: cnt SHALL increment.
REQ-015 WAIT_LOCK, lock_s high and cnt==DLY_CYC-1: FSM SHALL enter REL with cnt<=0 and idx<=0. This requires DLY_CYC consecutive high samples of lock_s.
REQ-016 REL, cnt<DLY_CYC-1: cnt SHALL increment.
REQ-017 REL, cnt==DLY_CYC-1:
- o_srst[idx] SHALL be cleared and cnt<=0.
- If idx<N_DOM-1: idx SHALL increment.
- If idx==N_DOM-1: FSM SHALL enter RUN and o_ready<=1 on the same edge.
REQ-018 Once cleared, a domain's o_srst bit SHALL stay low until the FSM enters ASSERT; bits SHALL release strictly in ascending order, DLY_CYC cycles apart.
REQ-019 In WAIT_LOCK, REL or RUN: lock_s low (in REL/RUN) or i_sw_rst high SHALL move the FSM to ASSERT on the next edge, with o_srst<=all ones, o_ready<=0, cnt<=0, idx<=0.
REQ-020 Simultaneous lock loss and i_sw_rst SHALL behave as a single ASSERT entry.
REQ-021 In WAIT_LOCK, lock_s low SHALL only clear cnt (REQ-013), not enter ASSERT.
REQ-022 ASSERT SHALL hold o_srst all ones for DLY_CYC cycles (cnt counts 0..DLY_CYC-1), then enter WAIT_LOCK with cnt<=0.
REQ-023 While in ASSERT, i_sw_rst and lock_s SHALL be ignored; the hold interval is never restarted or shortened.
REQ-024 A REL release edge coinciding with lock loss or i_sw_rst SHALL take ASSERT; no bit is released on that edge.
REQ-025 o_state SHALL equal the encoding of the registered current state.

Reset
REQ-026 While i_arst is high, asynchronously:
- o_srst = all ones, o_ready = 0, o_state = WAIT_LOCK (0).
- cnt = 0, idx = 0, both synchronizer flops = 0.
REQ-027 Deassertion of i_arst SHALL need no synchronization inside this block; the upstream source is already synchronized to i_clk.
REQ-028 i_arst asserted mid-sequence (any state) SHALL immediately restore the REQ-026 values, discarding all progress.

Verification
(N_DOM=3, DLY_CYC=4; edge 1 = first posedge after i_arst falls; i_pll_lock high throughout unless stated.)
REQ-029 Cold start -> lock_s high after edge 2; REL entered at edge 6; o_srst 111->110 at edge 10, ->100 at edge 14, ->000 and o_ready=1 at edge 18; o_state 0,1,2 at edges 0, 6, 18.
REQ-030 Lock glitch low for 1 cycle during WAIT_LOCK at edge 4 -> cnt cleared; REL entry delayed so domain 0 releases no earlier than 4+4 cycles after lock_s returns high; no ASSERT entry.
REQ-031 i_sw_rst 1-cycle pulse in RUN -> next edge o_srst=111, o_ready=0, o_state=3; 4 edges later o_state=0; full re-sequence as in REQ-029 relative to that point.
REQ-032 i_pll_lock falls in REL after domain 0 released -> ASSERT; o_srst=111; remains in WAIT_LOCK until lock returns and qualifies for 4 cycles.
REQ-033 i_sw_rst held high continuously, including while in ASSERT -> hold lasts exactly 4 cycles; then WAIT_LOCK for 1 edge, then ASSERT again; o_srst never deasserts.
REQ-034 i_arst pulsed while o_srst=100 -> outputs immediately 111/0/0 without a clock edge; sequence restarts per REQ-029.
